lpc_io_target: RTL

LPC bus I/O-cycle target front-end for the FPGA register file. It decodes host I/O read/write cycles on LFRAME#/LAD[3:0], claims a 32-byte I/O window, and issues single-cycle register writes (Addr/Wr/DataWr). It returns read data (DataRd) to the host with the LPC SYNC/TAR protocol. It sits between the board LPC pins and the register array, driving that array's write port and reading its selected byte.

---
 rtl/lpc_io_target_if.sv | 29 ++
 rtl/lpc_io_target.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lpc_io_target_if.sv
//------------------------------------------------------------------------------
// Module      : lpc_io_target_if
// Description : LPC pin bundle plus register-file write/read port
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lpc_io_target_if;
    logic       LFrame_n;
    logic [3:0] LadIn;
    logic [3:0] LadOut;
    logic       LadOe;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWr;
    logic [7:0] DataRd;

    modport slave (
        input  LFrame_n, LadIn, DataRd,
        output LadOut, LadOe, Addr, Wr, DataWr
    );

    modport master (
        output LFrame_n, LadIn, DataRd,
        input  LadOut, LadOe, Addr, Wr, DataWr
    );
endinterface

`default_nettype wire

// File: rtl/lpc_io_target.sv
//------------------------------------------------------------------------------
// Module      : lpc_io_target
// Description : LPC I/O-cycle target claiming a 32-byte window of registers
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0700,
    parameter int          SHORT_WAITS = 0
) (
    input  logic           LpcClock,
    input  logic           PciReset,
    lpc_io_target_if.slave bus
);

    localparam logic [2:0] c_SW = 3'(SHORT_WAITS);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CYCTYPE = 4'd1,
        ST_ADDR0   = 4'd2,
        ST_ADDR1   = 4'd3,
        ST_ADDR2   = 4'd4,
        ST_ADDR3   = 4'd5,
        ST_WDATA0  = 4'd6,
        ST_WDATA1  = 4'd7,
        ST_HTAR0   = 4'd8,
        ST_HTAR1   = 4'd9,
        ST_SYNC    = 4'd10,
        ST_RDATA0  = 4'd11,
        ST_RDATA1  = 4'd12,
        ST_PTAR0   = 4'd13,
        ST_PTAR1   = 4'd14
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [11:0] addr_q, addr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  lad_out_q, lad_out_d;
    logic        lad_oe_q, lad_oe_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_wr_q, data_wr_d;
    logic [15:0] full_addr;
    logic        addr_hit;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        reg_addr_d = reg_addr_q;
        data_wr_d  = data_wr_q;
        full_addr  = {addr_q, bus.LadIn};
        addr_hit   = (full_addr[15:5] == BASE_ADDR[15:5]);

        // LFRAME# mid-cycle: 0000 restarts, anything else abandons the cycle
        if (state_q != ST_IDLE && !bus.LFrame_n) begin
            state_d = (bus.LadIn == 4'b0000) ? ST_CYCTYPE : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.LFrame_n && bus.LadIn == 4'b0000) state_d = ST_CYCTYPE;
                end
                ST_CYCTYPE: begin
                    dir_d   = bus.LadIn[1];
                    state_d = (bus.LadIn[3:2] == 2'b00) ? ST_ADDR0 : ST_IDLE;
                end
                ST_ADDR0, ST_ADDR1, ST_ADDR2: begin
                    addr_d  = {addr_q[7:0], bus.LadIn};
                    state_d = state_t'(state_q + 4'd1);
                end
                ST_ADDR3: begin
                    if (addr_hit) begin
                        reg_addr_d = {3'b000, full_addr[4:0]};
                        state_d    = dir_q ? ST_WDATA0 : ST_HTAR0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WDATA0: begin
                    data_wr_d = {data_wr_q[7:4], bus.LadIn};
                    state_d   = ST_WDATA1;
                end
                ST_WDATA1: begin
                    data_wr_d = {bus.LadIn, data_wr_q[3:0]};
                    state_d   = ST_HTAR0;
                end
                ST_HTAR0: state_d = ST_HTAR1;
                ST_HTAR1: begin
                    cnt_d   = 3'd0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (cnt_q == c_SW) begin
                        hold_d  = bus.DataRd;
                        state_d = dir_q ? ST_PTAR0 : ST_RDATA0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_RDATA0: state_d = ST_RDATA1;
                ST_RDATA1: state_d = ST_PTAR0;
                ST_PTAR0:  state_d = ST_PTAR1;
                ST_PTAR1:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with it
        lad_oe_d = (state_d == ST_SYNC) || (state_d == ST_RDATA0) ||
                   (state_d == ST_RDATA1) || (state_d == ST_PTAR0);
        unique case (state_d)
            ST_SYNC:   lad_out_d = (cnt_d == c_SW) ? 4'b0000 : 4'b0101;
            ST_RDATA0: lad_out_d = hold_d[3:0];
            ST_RDATA1: lad_out_d = hold_q[7:4];
            default:   lad_out_d = 4'hF;
        endcase
        wr_d = dir_d && (state_d == ST_SYNC) && (cnt_d == c_SW);
    end

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            addr_q     <= 12'h000;
            cnt_q      <= 3'd0;
            hold_q     <= 8'h00;
            lad_out_q  <= 4'hF;
            lad_oe_q   <= 1'b0;
            reg_addr_q <= 8'h00;
            wr_q       <= 1'b0;
            data_wr_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            lad_out_q  <= lad_out_d;
            lad_oe_q   <= lad_oe_d;
            reg_addr_q <= reg_addr_d;
            wr_q       <= wr_d;
            data_wr_q  <= data_wr_d;
        end
    end

    assign bus.LadOut = lad_out_q;
    assign bus.LadOe  = lad_oe_q;
    assign bus.Addr   = reg_addr_q;
    assign bus.Wr     = wr_q;
    assign bus.DataWr = data_wr_q;

endmodule

`default_nettype wire
